// File: rtl/cavlc_blk_pkg.sv
// Shared definitions for the CAVLC residual-block sequencer.
// Holds the cavlc_decoder_state encodings, which the LUT decoders and the
// coefficient datapath decode directly, and the legal maxNumCoeff values.
package cavlc_blk_pkg;

   localparam int unsigned CAVLC_STATE_W = 4;

   // Plain binary encodings. The downstream datapath compares against these
   // values unchanged, so they must not be reordered.
   typedef enum logic [CAVLC_STATE_W-1:0] {
      Idle                = 4'd0,
      CoeffToken          = 4'd1,
      T1Sign              = 4'd2,
      Level               = 4'd3,
      TotalZeros          = 4'd4,
      RunBefore           = 4'd5,
      LevelRunCombination = 4'd6
   } cavlc_state_e;

   localparam logic [4:0] MAX_NUM_COEFF_CHROMA_DC = 5'd4;
   localparam logic [4:0] MAX_NUM_COEFF_AC        = 5'd15;
   localparam logic [4:0] MAX_NUM_COEFF_4X4       = 5'd16;

endpackage

// File: rtl/cavlc_blk_counters.sv
// Counter bank for the CAVLC block sequencer.
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   clr                      clear every counter (start of a new block)
//   level_ld/level_val       load i_level; level_inc increments it
//   run_clr/run_inc          clear / increment i_run
//   zl_ld/zl_val             load zerosLeft
//   tc_ld/tc_val             load i_TotalCoeff; tc_dec decrements it
//   i_level, i_run, zerosLeft, i_TotalCoeff   counter values
module cavlc_blk_counters (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       level_ld,
   input  logic [4:0] level_val,
   input  logic       level_inc,
   input  logic       run_clr,
   input  logic       run_inc,
   input  logic       zl_ld,
   input  logic [3:0] zl_val,
   input  logic       tc_ld,
   input  logic [4:0] tc_val,
   input  logic       tc_dec,
   output logic [4:0] i_level,
   output logic [3:0] i_run,
   output logic [3:0] zerosLeft,
   output logic [4:0] i_TotalCoeff
);

   logic [4:0] level_q;
   logic [3:0] run_q;
   logic [3:0] zl_q;
   logic [4:0] tc_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         level_q <= '0;
         run_q   <= '0;
         zl_q    <= '0;
         tc_q    <= '0;
      end else begin
         if (level_ld) begin
            level_q <= level_val;
         end else if (level_inc) begin
            level_q <= level_q + 5'd1;
         end

         if (run_clr) begin
            run_q <= '0;
         end else if (run_inc) begin
            run_q <= run_q + 4'd1;
         end

         if (zl_ld) begin
            zl_q <= zl_val;
         end

         if (tc_ld) begin
            tc_q <= tc_val;
         end else if (tc_dec) begin
            tc_q <= tc_q - 5'd1;
         end
      end
   end

   assign i_level      = level_q;
   assign i_run        = run_q;
   assign zerosLeft    = zl_q;
   assign i_TotalCoeff = tc_q;

endmodule

// File: rtl/cavlc_blk_sequencer.sv
// CAVLC residual-block sequencer: walks one 4x4 / AC / chroma-DC block through
// coeff_token, trailing-ones sign, levels, total_zeros, run_before and the
// level/run combination phase, and flags the end of the block.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   start                      begin one block (ignored while busy)
//   maxNumCoeff                4, 15 or 16; latched on start
//   coeff_token_valid, TotalCoeff, TrailingOnes   coeff_token LUT result
//   t1_sign_valid              trailing-ones signs parsed
//   level_valid                one level decoded
//   total_zeros_valid, total_zeros                total_zeros LUT result
//   run_before_valid, run_before                  one run_before decoded
//   cavlc_decoder_state        current state (LUT decoder enables)
//   i_level, i_run, zerosLeft, i_TotalCoeff       counters
//   end_of_NonZeroCoeff_CAVLC  last combination cycle strobe
//   blk_done                   one-cycle pulse after the last combination cycle
//   busy                       state != Idle
//   err                        sticky syntax error, cleared by start or reset
module cavlc_blk_sequencer
   import cavlc_blk_pkg::*;
#(
   parameter int unsigned MAX_COEFF = 16,
   parameter int unsigned STATE_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [4:0]         maxNumCoeff,
   input  logic               coeff_token_valid,
   input  logic [4:0]         TotalCoeff,
   input  logic [1:0]         TrailingOnes,
   input  logic               t1_sign_valid,
   input  logic               level_valid,
   input  logic               total_zeros_valid,
   input  logic [3:0]         total_zeros,
   input  logic               run_before_valid,
   input  logic [3:0]         run_before,
   output logic [STATE_W-1:0] cavlc_decoder_state,
   output logic [4:0]         i_level,
   output logic [3:0]         i_run,
   output logic [3:0]         zerosLeft,
   output logic [4:0]         i_TotalCoeff,
   output logic               end_of_NonZeroCoeff_CAVLC,
   output logic               blk_done,
   output logic               busy,
   output logic               err
);

   localparam logic [4:0] MaxCoeffW = 5'(MAX_COEFF);

   cavlc_state_e state_q, state_d;
   logic [4:0]   tc_q, max_q;
   logic [1:0]   t1_q;
   logic         err_q, err_d;
   logic         done_q, done_d;
   logic         tok_ld, max_ld;

   logic         cnt_clr, level_ld, level_inc, run_clr, run_inc, zl_ld, tc_ld, tc_dec;
   logic [4:0]   level_val, tc_val;
   logic [3:0]   zl_val;

   logic         post_level;
   logic [4:0]   eff_max;
   logic [4:0]   tc_m1;
   logic [4:0]   lvl_next;
   logic [4:0]   run_next;
   logic [4:0]   tz_limit;
   logic [3:0]   tz_clamped;
   logic [3:0]   zl_after_run;

   // The legality check honours the smaller of the block's maxNumCoeff and
   // what the counters were sized for.
   assign eff_max  = (max_q > MaxCoeffW) ? MaxCoeffW : max_q;
   assign tc_m1    = tc_q - 5'd1;
   assign lvl_next = i_level + 5'd1;
   assign run_next = {1'b0, i_run} + 5'd1;
   assign tz_limit = max_q - tc_q;

   // tz_limit only clamps when it is below total_zeros, so it fits in 4 bits there.
   assign tz_clamped   = ({1'b0, total_zeros} > tz_limit) ? tz_limit[3:0] : total_zeros;
   assign zl_after_run = (run_before > zerosLeft) ? 4'd0 : (zerosLeft - run_before);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= Idle;
         tc_q    <= '0;
         t1_q    <= '0;
         max_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         done_q  <= done_d;
         if (max_ld) begin
            max_q <= maxNumCoeff;
         end
         if (tok_ld) begin
            tc_q <= TotalCoeff;
            t1_q <= TrailingOnes;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      done_d     = 1'b0;
      tok_ld     = 1'b0;
      max_ld     = 1'b0;
      cnt_clr    = 1'b0;
      level_ld   = 1'b0;
      level_val  = '0;
      level_inc  = 1'b0;
      run_clr    = 1'b0;
      run_inc    = 1'b0;
      zl_ld      = 1'b0;
      zl_val     = '0;
      tc_ld      = 1'b0;
      tc_val     = '0;
      tc_dec     = 1'b0;
      post_level = 1'b0;

      case (state_q)
         Idle: begin
            if (start) begin
               state_d = CoeffToken;
               err_d   = 1'b0;
               cnt_clr = 1'b1;
               max_ld  = 1'b1;
            end
         end

         CoeffToken: begin
            if (coeff_token_valid) begin
               tok_ld = 1'b1;
               if (TotalCoeff == 5'd0) begin
                  // Empty block: a single combination cycle with the strobe up.
                  state_d = LevelRunCombination;
                  tc_ld   = 1'b1;
                  tc_val  = 5'd0;
               end else if ((TotalCoeff > eff_max) || ({3'b0, TrailingOnes} > TotalCoeff)) begin
                  state_d = Idle;
                  err_d   = 1'b1;
               end else if (TrailingOnes != 2'd0) begin
                  state_d = T1Sign;
               end else begin
                  state_d   = Level;
                  level_ld  = 1'b1;
                  level_val = 5'd0;
               end
            end
         end

         T1Sign: begin
            if (t1_sign_valid) begin
               level_ld  = 1'b1;
               level_val = {3'b0, t1_q};
               if ({3'b0, t1_q} == tc_q) begin
                  post_level = 1'b1;
               end else begin
                  state_d = Level;
               end
            end
         end

         Level: begin
            if (level_valid) begin
               level_inc = 1'b1;
               if (lvl_next == tc_q) begin
                  post_level = 1'b1;
               end
            end
         end

         TotalZeros: begin
            if (total_zeros_valid) begin
               if ({1'b0, total_zeros} > tz_limit) begin
                  err_d = 1'b1;
               end
               zl_ld   = 1'b1;
               zl_val  = tz_clamped;
               run_clr = 1'b1;
               if ((tz_clamped == 4'd0) || (tc_q == 5'd1)) begin
                  state_d = LevelRunCombination;
                  tc_ld   = 1'b1;
                  tc_val  = tc_m1;
               end else begin
                  state_d = RunBefore;
               end
            end
         end

         RunBefore: begin
            if (run_before_valid) begin
               if (run_before > zerosLeft) begin
                  err_d = 1'b1;
               end
               zl_ld   = 1'b1;
               zl_val  = zl_after_run;
               run_inc = 1'b1;
               if ((zl_after_run == 4'd0) || (run_next == tc_m1)) begin
                  state_d = LevelRunCombination;
                  tc_ld   = 1'b1;
                  tc_val  = tc_m1;
               end
            end
         end

         LevelRunCombination: begin
            if (i_TotalCoeff == 5'd0) begin
               state_d = Idle;
               done_d  = 1'b1;
            end else begin
               tc_dec = 1'b1;
            end
         end

         default: begin
            state_d = Idle;
         end
      endcase

      // Shared exit once every level of the block has been decoded.
      if (post_level) begin
         if (tc_q == max_q) begin
            state_d = LevelRunCombination;
            zl_ld   = 1'b1;
            zl_val  = 4'd0;
            tc_ld   = 1'b1;
            tc_val  = tc_m1;
         end else begin
            state_d = TotalZeros;
         end
      end
   end

   cavlc_blk_counters u_counters (
      .clk          (clk),
      .reset        (reset),
      .clr          (cnt_clr),
      .level_ld     (level_ld),
      .level_val    (level_val),
      .level_inc    (level_inc),
      .run_clr      (run_clr),
      .run_inc      (run_inc),
      .zl_ld        (zl_ld),
      .zl_val       (zl_val),
      .tc_ld        (tc_ld),
      .tc_val       (tc_val),
      .tc_dec       (tc_dec),
      .i_level      (i_level),
      .i_run        (i_run),
      .zerosLeft    (zerosLeft),
      .i_TotalCoeff (i_TotalCoeff)
   );

   assign cavlc_decoder_state       = STATE_W'(state_q);
   assign end_of_NonZeroCoeff_CAVLC = (state_q == LevelRunCombination) && (i_TotalCoeff == 5'd0);
   assign blk_done                  = done_q;
   assign busy                      = (state_q != Idle);
   assign err                       = err_q;

endmodule

// File: tb/tb_cavlc_blk_sequencer.sv
// Directed bench for cavlc_blk_sequencer. Per-block expectations are queued
// when a block is driven and checked by a monitor when blk_done appears.
module tb_cavlc_blk_sequencer;
   import cavlc_blk_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [4:0] maxNumCoeff;
   logic       coeff_token_valid;
   logic [4:0] TotalCoeff;
   logic [1:0] TrailingOnes;
   logic       t1_sign_valid;
   logic       level_valid;
   logic       total_zeros_valid;
   logic [3:0] total_zeros;
   logic       run_before_valid;
   logic [3:0] run_before;
   logic [3:0] cavlc_decoder_state;
   logic [4:0] i_level;
   logic [3:0] i_run;
   logic [3:0] zerosLeft;
   logic [4:0] i_TotalCoeff;
   logic       end_of_NonZeroCoeff_CAVLC;
   logic       blk_done;
   logic       busy;
   logic       err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int lrc;
      bit err;
      bit saw_lvl;
      bit saw_tz;
      int zl;
      int lvl;
   } exp_t;
   exp_t q[$];

   cavlc_blk_sequencer #(
      .MAX_COEFF (16),
      .STATE_W   (4)
   ) dut (
      .clk                       (clk),
      .reset                     (reset),
      .start                     (start),
      .maxNumCoeff               (maxNumCoeff),
      .coeff_token_valid         (coeff_token_valid),
      .TotalCoeff                (TotalCoeff),
      .TrailingOnes              (TrailingOnes),
      .t1_sign_valid             (t1_sign_valid),
      .level_valid               (level_valid),
      .total_zeros_valid         (total_zeros_valid),
      .total_zeros               (total_zeros),
      .run_before_valid          (run_before_valid),
      .run_before                (run_before),
      .cavlc_decoder_state       (cavlc_decoder_state),
      .i_level                   (i_level),
      .i_run                     (i_run),
      .zerosLeft                 (zerosLeft),
      .i_TotalCoeff              (i_TotalCoeff),
      .end_of_NonZeroCoeff_CAVLC (end_of_NonZeroCoeff_CAVLC),
      .blk_done                  (blk_done),
      .busy                      (busy),
      .err                       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Per-block monitor: counts combination cycles and end strobes, records
   // visited states, and checks the queued expectation at blk_done.
   int lrc_n = 0;
   int str_n = 0;
   bit saw_l = 0;
   bit saw_t = 0;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         lrc_n = 0; str_n = 0; saw_l = 0; saw_t = 0;
      end else begin
         if (cavlc_decoder_state == 4'(CoeffToken)) begin
            lrc_n = 0; str_n = 0; saw_l = 0; saw_t = 0;
         end
         if (cavlc_decoder_state == 4'(LevelRunCombination)) lrc_n++;
         if (end_of_NonZeroCoeff_CAVLC) str_n++;
         if (cavlc_decoder_state == 4'(Level)) saw_l = 1;
         if (cavlc_decoder_state == 4'(TotalZeros)) saw_t = 1;
         if (blk_done) begin
            if (q.size() == 0) begin
               chk("unexpected_blk_done", 32'(blk_done), 0);
            end else begin
               e = q.pop_front();
               chk("lrc_cycles", lrc_n, e.lrc);
               chk("end_strobes", str_n, 1);
               chk("blk_err", 32'(err), 32'(e.err));
               chk("visited_level", 32'(saw_l), 32'(e.saw_lvl));
               chk("visited_total_zeros", 32'(saw_t), 32'(e.saw_tz));
               chk("final_zerosLeft", 32'(zerosLeft), e.zl);
               chk("final_i_level", 32'(i_level), e.lvl);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_blk(input int lrc, input bit e, input bit sl, input bit st,
                             input int zl, input int lvl);
      exp_t x;
      x.lrc = lrc; x.err = e; x.saw_lvl = sl; x.saw_tz = st; x.zl = zl; x.lvl = lvl;
      q.push_back(x);
   endtask

   task automatic do_start(input logic [4:0] mx);
      maxNumCoeff = mx;
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic tok(input logic [4:0] tc, input logic [1:0] t1);
      coeff_token_valid = 1'b1; TotalCoeff = tc; TrailingOnes = t1;
      cyc();
      coeff_token_valid = 1'b0;
   endtask

   task automatic t1s();
      t1_sign_valid = 1'b1; cyc(); t1_sign_valid = 1'b0;
   endtask

   task automatic lvl(input int n);
      for (int i = 0; i < n; i++) begin
         level_valid = 1'b1; cyc(); level_valid = 1'b0;
      end
   endtask

   task automatic tz(input logic [3:0] v);
      total_zeros_valid = 1'b1; total_zeros = v; cyc(); total_zeros_valid = 1'b0;
   endtask

   task automatic rb(input logic [3:0] v);
      run_before_valid = 1'b1; run_before = v; cyc(); run_before_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (!seen) begin
            cyc();
            if (blk_done) seen = 1;
         end
      end
      chk(tag, 32'(seen), 1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; maxNumCoeff = MAX_NUM_COEFF_4X4;
      coeff_token_valid = 1'b0; TotalCoeff = '0; TrailingOnes = '0;
      t1_sign_valid = 1'b0; level_valid = 1'b0; total_zeros_valid = 1'b0;
      total_zeros = '0; run_before_valid = 1'b0; run_before = '0;
      cyc(); cyc();
      reset = 1'b0;
      chk("rst_state", 32'(cavlc_decoder_state), 32'(Idle));
      chk("rst_counters", {i_level, i_run, zerosLeft, i_TotalCoeff}, 0);
      chk("rst_flags", {end_of_NonZeroCoeff_CAVLC, blk_done, busy, err}, 0);

      // Empty block.
      expect_blk(1, 0, 0, 0, 0, 0);
      do_start(MAX_NUM_COEFF_4X4);
      chk("b1_busy", 32'(busy), 1);
      tok(5'd0, 2'd0);
      chk("b1_state_lrc", 32'(cavlc_decoder_state), 32'(LevelRunCombination));
      chk("b1_strobe", 32'(end_of_NonZeroCoeff_CAVLC), 1);
      wait_done("b1_done");

      // TotalCoeff=5, T1=3, total_zeros=3, runs 1,2.
      expect_blk(5, 0, 1, 1, 0, 5);
      do_start(MAX_NUM_COEFF_4X4);
      tok(5'd5, 2'd3);
      chk("b2_state_t1", 32'(cavlc_decoder_state), 32'(T1Sign));
      start = 1'b1; level_valid = 1'b1; cyc(); start = 1'b0; level_valid = 1'b0;
      chk("b2_ignored_inputs", {27'(cavlc_decoder_state), i_level}, {27'(T1Sign), 5'd0});
      t1s();
      chk("b2_i_level_t1", 32'(i_level), 3);
      lvl(2);
      chk("b2_i_level_end", 32'(i_level), 5);
      chk("b2_state_tz", 32'(cavlc_decoder_state), 32'(TotalZeros));
      tz(4'd3);
      chk("b2_zl_tz", 32'(zerosLeft), 3);
      rb(4'd1);
      chk("b2_run1", {i_run, zerosLeft}, {4'd1, 4'd2});
      chk("b2_still_rb", 32'(cavlc_decoder_state), 32'(RunBefore));
      rb(4'd2);
      chk("b2_run2", {i_run, zerosLeft, i_TotalCoeff}, {4'd2, 4'd0, 5'd4});
      chk("b2_state_lrc", 32'(cavlc_decoder_state), 32'(LevelRunCombination));
      wait_done("b2_done");

      // Full 4x4 block, TotalZeros skipped.
      expect_blk(16, 0, 1, 0, 0, 16);
      do_start(MAX_NUM_COEFF_4X4);
      tok(5'd16, 2'd0);
      lvl(16);
      chk("b3_lrc_entry", {27'(cavlc_decoder_state), i_TotalCoeff},
          {27'(LevelRunCombination), 5'd15});
      wait_done("b3_done");

      // Chroma DC, all coefficients present.
      expect_blk(4, 0, 1, 0, 0, 4);
      do_start(MAX_NUM_COEFF_CHROMA_DC);
      tok(5'd4, 2'd3);
      t1s();
      chk("b4_state_level", 32'(cavlc_decoder_state), 32'(Level));
      lvl(1);
      chk("b4_lrc_entry", 32'(i_TotalCoeff), 3);
      wait_done("b4_done");

      // run_before larger than zerosLeft.
      expect_blk(2, 1, 1, 1, 0, 2);
      do_start(MAX_NUM_COEFF_4X4);
      tok(5'd2, 2'd0);
      lvl(2);
      tz(4'd1);
      rb(4'd3);
      chk("b5_err_zl", {err, zerosLeft}, {1'b1, 4'd0});
      wait_done("b5_done");

      // total_zeros above maxNumCoeff-TotalCoeff is clamped.
      expect_blk(2, 1, 1, 1, 2, 2);
      do_start(MAX_NUM_COEFF_CHROMA_DC);
      chk("b6_err_cleared", 32'(err), 0);
      tok(5'd2, 2'd0);
      lvl(2);
      tz(4'd5);
      chk("b6_clamp", {err, zerosLeft}, {1'b1, 4'd2});
      rb(4'd0);
      chk("b6_lrc_entry", 32'(cavlc_decoder_state), 32'(LevelRunCombination));
      wait_done("b6_done");

      // TotalCoeff above maxNumCoeff: error, back to Idle, no blk_done.
      do_start(MAX_NUM_COEFF_CHROMA_DC);
      tok(5'd5, 2'd0);
      chk("b7_err_idle", {err, busy, blk_done}, {1'b1, 1'b0, 1'b0});

      // Reset in RunBefore aborts the block.
      do_start(MAX_NUM_COEFF_4X4);
      chk("b8_err_cleared", 32'(err), 0);
      tok(5'd5, 2'd0);
      lvl(5);
      tz(4'd4);
      rb(4'd1);
      chk("b8_in_rb", {27'(cavlc_decoder_state), zerosLeft}, {27'(RunBefore), 4'd3});
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("b8_reset_state", 32'(cavlc_decoder_state), 32'(Idle));
      chk("b8_reset_counters", {i_level, i_run, zerosLeft, i_TotalCoeff}, 0);
      cyc();
      chk("b8_no_done", {blk_done, busy}, 0);

      // Single trailing one after reset.
      expect_blk(1, 0, 0, 1, 2, 1);
      do_start(MAX_NUM_COEFF_AC);
      tok(5'd1, 2'd1);
      t1s();
      chk("b9_state_tz", 32'(cavlc_decoder_state), 32'(TotalZeros));
      tz(4'd2);
      chk("b9_lrc", {27'(cavlc_decoder_state), i_TotalCoeff},
          {27'(LevelRunCombination), 5'd0});
      wait_done("b9_done");

      cyc();
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
